crossyroad_lane_engine: RTL

//  Parametrised N-lane obstacle engine and game-state core for the VGA Crossy Road game. It replaces the fixed
//  two-obstacle scroll logic with NUM_LANES lanes in alternating directions and a speed that rises with score.

---
 rtl/crossyroad_lane_engine_if.sv | 23 ++
 rtl/crossyroad_lane_engine.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/crossyroad_lane_engine_if.sv
// Signal bundle between the VGA timing/input side and the Crossy Road lane engine.
// The master drives button, frame and pixel information; the slave returns game state and colour.
interface crossyroad_lane_engine_if;
   logic       move_btn;
   logic       frame_tick;
   logic       video_on;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic [7:0] score;
   logic [1:0] state;
   logic [1:0] lives;
   logic [2:0] rgb;

   modport master (
      output move_btn, frame_tick, video_on, pixel_x, pixel_y,
      input  score, state, lives, rgb
   );

   modport slave (
      input  move_btn, frame_tick, video_on, pixel_x, pixel_y,
      output score, state, lives, rgb
   );
endinterface

// File: rtl/crossyroad_lane_engine.sv
// N-lane obstacle engine and IDLE/PLAY/HIT game core for VGA Crossy Road.
// Optional feature: define CROSSY_LIVES_EN for three lives with resume-after-hit.
module crossyroad_lane_engine #(
   parameter int NUM_LANES     = 4,
   parameter int LANE_SPACING  = 120,
   parameter int LANE_X_OFFSET = 160,
   parameter int SCREEN_W      = 640,
   parameter int SCREEN_H      = 480,
   parameter int OB_W          = 50,
   parameter int OB_H          = 30,
   parameter int CHICKEN_X     = 310,
   parameter int CHICKEN_Y     = 400,
   parameter int CHICKEN_W     = 30,
   parameter int CHICKEN_H     = 40,
   parameter int SCROLL_STEP   = 10,
   parameter int HIT_FRAMES    = 60
) (
   input logic                    clk,
   input logic                    reset,
   crossyroad_lane_engine_if.slave bus
);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_HIT = 2'd2} state_t;

   // Counter must hold HIT_FRAMES-1 and always have a bit 3 for the blink.
   localparam int HC_W = ($clog2(HIT_FRAMES) > 4) ? $clog2(HIT_FRAMES) : 4;

   state_t            state_q, state_next;
   logic [2:0]        btn_q;
   logic              press;
   logic [7:0]        score_q;
   logic [HC_W-1:0]   hit_cnt;
   logic              coll_flag;
   logic [2:0]        rgb_q;
   logic [9:0]        lane_x [NUM_LANES];
   logic [9:0]        lane_y [NUM_LANES];
   logic [NUM_LANES-1:0] ob_hit;
   logic              ob_any, chick;
   logic [10:0]       px, py;
   logic [2:0]        spd;
   logic              restore, load_hit, dec_hit, play_press, play_tick;
`ifdef CROSSY_LIVES_EN
   logic [1:0]        lives_q;
   logic              lose_life;
`endif

   function automatic logic [9:0] init_x(input int i);
      return 10'((i * LANE_X_OFFSET) % SCREEN_W);
   endfunction

   function automatic logic [9:0] init_y(input int i);
      return 10'((i * LANE_SPACING) % SCREEN_H);
   endfunction

   function automatic logic [9:0] scroll_y(input logic [9:0] y);
      logic [10:0] s;
      s = {1'b0, y} + 11'(SCROLL_STEP);
      if (s >= 11'(SCREEN_H)) s = s - 11'(SCREEN_H);
      return s[9:0];
   endfunction

   function automatic logic [9:0] move_x(input logic [9:0] x, input logic odd, input logic [2:0] v);
      logic [10:0] s;
      if (!odd) begin
         s = {1'b0, x} + {8'd0, v};
         if (s >= 11'(SCREEN_W)) s = s - 11'(SCREEN_W);
      end else if ({1'b0, x} < {8'd0, v}) begin
         s = {1'b0, x} + 11'(SCREEN_W) - {8'd0, v};
      end else begin
         s = {1'b0, x} - {8'd0, v};
      end
      return s[9:0];
   endfunction

   // btn_q[1:0] synchronise the raw button, btn_q[2] is the previous synchronised level.
   assign press = btn_q[1] & ~btn_q[2];
   assign spd   = 3'd1 + {1'b0, score_q[7:6]};
   assign px    = {1'b0, bus.pixel_x};
   assign py    = {1'b0, bus.pixel_y};

   // Obstacles are clipped at the screen edge: spans are compared with 11-bit sums, never wrapped.
   always_comb begin
      ob_hit = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         ob_hit[i] = (px >= {1'b0, lane_x[i]}) && (px < {1'b0, lane_x[i]} + 11'(OB_W)) &&
                     (py >= {1'b0, lane_y[i]}) && (py < {1'b0, lane_y[i]} + 11'(OB_H));
      end
   end

   assign ob_any = |ob_hit;
   assign chick  = (px >= 11'(CHICKEN_X)) && (px < 11'(CHICKEN_X + CHICKEN_W)) &&
                   (py >= 11'(CHICKEN_Y)) && (py < 11'(CHICKEN_Y + CHICKEN_H));

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      state_next = state_q;
      restore    = 1'b0;
      load_hit   = 1'b0;
      dec_hit    = 1'b0;
      play_press = 1'b0;
      play_tick  = 1'b0;
`ifdef CROSSY_LIVES_EN
      lose_life  = 1'b0;
`endif
      case (state_q)
         ST_IDLE: if (press) state_next = ST_PLAY;
         ST_PLAY: begin
            play_press = press;
            play_tick  = bus.frame_tick;
            if (bus.frame_tick && coll_flag) begin
               state_next = ST_HIT;
               load_hit   = 1'b1;
            end
         end
         ST_HIT: begin
            if (bus.frame_tick) begin
               if (hit_cnt == '0) begin
`ifdef CROSSY_LIVES_EN
                  lose_life = 1'b1;
                  if (lives_q == 2'd1) begin
                     state_next = ST_IDLE;
                     restore    = 1'b1;
                  end else begin
                     state_next = ST_PLAY;
                  end
`else
                  state_next = ST_IDLE;
                  restore    = 1'b1;
`endif
               end else begin
                  dec_hit = 1'b1;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   // NOTE: lane arrays are small register files, so they are reset explicitly rather than left as RAM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         btn_q     <= '0;
         score_q   <= '0;
         hit_cnt   <= '0;
         coll_flag <= 1'b0;
         rgb_q     <= '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            lane_x[i] <= init_x(i);
            lane_y[i] <= init_y(i);
         end
      end else begin
         state_q <= state_next;
         btn_q   <= {btn_q[1:0], bus.move_btn};

         if (bus.frame_tick || restore) coll_flag <= 1'b0;
         else if (state_q == ST_PLAY && bus.video_on && ob_any && chick) coll_flag <= 1'b1;

         if (load_hit)     hit_cnt <= HC_W'(HIT_FRAMES - 1);
         else if (dec_hit) hit_cnt <= hit_cnt - 1'b1;
         else if (restore) hit_cnt <= '0;

         if (restore) score_q <= '0;
         else if (play_press && score_q != 8'hFF) score_q <= score_q + 8'd1;

         for (int i = 0; i < NUM_LANES; i++) begin
            if (restore) begin
               lane_x[i] <= init_x(i);
               lane_y[i] <= init_y(i);
            end else begin
               if (play_press) lane_y[i] <= scroll_y(lane_y[i]);
               if (play_tick)  lane_x[i] <= move_x(lane_x[i], (i % 2) == 1, spd);
            end
         end

         if (!bus.video_on)                           rgb_q <= 3'b000;
         else if (ob_any && chick)                    rgb_q <= 3'b011;
         else if (chick && state_q == ST_HIT && hit_cnt[3]) rgb_q <= 3'b000;
         else if (ob_any)                             rgb_q <= 3'b100;
         else if (chick)                              rgb_q <= 3'b010;
         else                                         rgb_q <= 3'b001;
      end
   end

`ifdef CROSSY_LIVES_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          lives_q <= 2'd3;
      else if (restore)   lives_q <= 2'd3;
      else if (lose_life) lives_q <= lives_q - 2'd1;
   end
   assign bus.lives = lives_q;
`else
   assign bus.lives = 2'd1;
`endif

   assign bus.score = score_q;
   assign bus.state = state_q;
   assign bus.rgb   = rgb_q;

endmodule
